clkswitch_seq: RTL and testbench

- Parametrised, glitch-free CPU clock switcher. Sequences the CPU clock between the host 2MHz clock (lsclk_in) and a divided tap of the local high-speed oscillator (hsclk_in).
- Control FSM runs on lsclk_in. Enable flops and retime pipelines sit in both clock domains.
- Adds to the earlier switcher: parametrised divider depth and sync depth, divider-ratio latching only at switch time, a minimum high-speed dwell counter, and an explicit busy/status interface.
- Sits between the address-decode logic (which raises hs_req for fast regions) and the 65816 PHI2 input.

---
 rtl/clkswitch_pkg.sv | 21 ++
 rtl/clkdiv_chain.sv | 36 +++
 rtl/clkswitch_seq.sv | 134 +++++++++++++
 tb/tb_clkswitch_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkswitch_pkg.sv
// clkswitch_pkg: shared types and helpers for the glitch-free CPU clock switcher.
// Holds the sequencer state encoding and the tap-select clamp.
package clkswitch_pkg;

   typedef enum logic [2:0] {
      LS_RUN,
      LS_OFF,
      HS_ON,
      HS_RUN,
      HS_OFF,
      LS_ON
   } sw_state_e;

   function automatic int unsigned tap_clamp(
      input int unsigned sel,
      input int unsigned max_tap
   );
      return (sel > max_tap) ? max_tap : sel;
   endfunction

endpackage

// File: rtl/clkdiv_chain.sv
// clkdiv_chain: ripple divide-by-2 chain on the HS oscillator plus tap mux.
// The mux is steered only by the latched tap, so it moves while the HS path is gated.
module clkdiv_chain #(
   parameter int DIV_STAGES = 3,
   parameter int SEL_W      = 2
) (
   input  logic             i_hsclk,
   input  logic             i_rst_b,
   input  logic [SEL_W-1:0] i_div_active,
   output logic             o_hs_tap
);

   logic [DIV_STAGES:0] w_tap;
   logic                w_mux;

   assign w_tap[0] = i_hsclk;

   for (genvar k = 0; k < DIV_STAGES; k++) begin : g_stage
      logic r_q;
      always_ff @(negedge w_tap[k] or negedge i_rst_b) begin
         if (!i_rst_b) r_q <= 1'b0;
         else          r_q <= ~r_q;
      end
      assign w_tap[k+1] = r_q;
   end

   always_comb begin
      w_mux = w_tap[0];
      for (int i = 1; i <= DIV_STAGES; i++) begin
         if (i_div_active == SEL_W'(i)) w_mux = w_tap[i];
      end
   end

   assign o_hs_tap = w_mux;

endmodule

// File: rtl/clkswitch_seq.sv
// clkswitch_seq: glitch-free PHI2 switcher between lsclk_in and a divided HS tap.
// Break-before-make sequencer on lsclk_in with enables retimed across both domains.
module clkswitch_seq
   import clkswitch_pkg::*;
#(
   parameter int DIV_STAGES = 3,
   parameter int SEL_W      = 2,
   parameter int PIPE_SZ    = 2,
   parameter int DWELL      = 4,
   parameter int DWELL_W    = 3
) (
   input  logic             lsclk_in,
   input  logic             rst_b,
   input  logic             hsclk_in,
   input  logic             hs_req,
   input  logic [SEL_W-1:0] div_sel,
   output logic             clkout,
   output logic             ls_selected,
   output logic             hs_selected,
   output logic             busy,
   output logic [SEL_W-1:0] div_active
);

   sw_state_e          r_state;
   logic               r_ls_req;
   logic               r_hs_req;
   logic               r_ls_enable;
   logic               r_hs_enable;
   logic [PIPE_SZ-1:0] r_ls_sync;
   logic [PIPE_SZ-1:0] r_hs_sync;
   logic [DWELL_W-1:0] r_dwell;
   logic               r_busy;
   logic               r_ls_sel;
   logic               r_hs_sel;
   logic [SEL_W-1:0]   r_div_active;
   logic               w_hs_tap;
   logic               w_ls_sync_q;
   logic               w_hs_sync_q;

   clkdiv_chain #(
      .DIV_STAGES (DIV_STAGES),
      .SEL_W      (SEL_W)
   ) u_div (
      .i_hsclk      (hsclk_in),
      .i_rst_b      (rst_b),
      .i_div_active (r_div_active),
      .o_hs_tap     (w_hs_tap)
   );

   assign w_ls_sync_q = r_ls_sync[PIPE_SZ-1];
   assign w_hs_sync_q = r_hs_sync[PIPE_SZ-1];

   always_ff @(negedge lsclk_in or negedge rst_b) begin
      if (!rst_b) r_ls_enable <= 1'b1;
      else        r_ls_enable <= r_ls_req;
   end

   // HS gate cannot open while the retimed LS enable is still seen high
   always_ff @(negedge w_hs_tap or negedge rst_b) begin
      if (!rst_b) r_hs_enable <= 1'b0;
      else        r_hs_enable <= r_hs_req & ~w_ls_sync_q;
   end

   always_ff @(negedge w_hs_tap or negedge rst_b or posedge r_ls_enable) begin
      if (!rst_b)           r_ls_sync <= '1;
      else if (r_ls_enable) r_ls_sync <= '1;
      else                  r_ls_sync <= {r_ls_sync[PIPE_SZ-2:0], 1'b0};
   end

   always_ff @(negedge lsclk_in or negedge rst_b or posedge r_hs_enable) begin
      if (!rst_b)           r_hs_sync <= '0;
      else if (r_hs_enable) r_hs_sync <= '1;
      else                  r_hs_sync <= {r_hs_sync[PIPE_SZ-2:0], 1'b0};
   end

   always_ff @(posedge lsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         r_state      <= LS_RUN;
         r_ls_req     <= 1'b1;
         r_hs_req     <= 1'b0;
         r_dwell      <= '0;
         r_busy       <= 1'b0;
         r_ls_sel     <= 1'b1;
         r_hs_sel     <= 1'b0;
         r_div_active <= '0;
      end else begin
         unique case (r_state)
            LS_RUN: if (hs_req) begin
               r_div_active <= SEL_W'(tap_clamp(32'(div_sel), 32'(DIV_STAGES)));
               r_busy       <= 1'b1;
               r_ls_sel     <= 1'b0;
               r_ls_req     <= 1'b0;
               r_state      <= LS_OFF;
            end
            LS_OFF: if (!r_ls_enable && !w_ls_sync_q) begin
               r_hs_req <= 1'b1;
               r_state  <= HS_ON;
            end
            HS_ON: if (w_hs_sync_q) begin
               r_hs_sel <= 1'b1;
               r_busy   <= 1'b0;
               r_dwell  <= '0;
               r_state  <= HS_RUN;
            end
            HS_RUN: begin
               if (r_dwell != DWELL_W'(DWELL)) r_dwell <= r_dwell + 1'b1;
               if (!hs_req && r_dwell == DWELL_W'(DWELL)) begin
                  r_busy   <= 1'b1;
                  r_hs_sel <= 1'b0;
                  r_hs_req <= 1'b0;
                  r_state  <= HS_OFF;
               end
            end
            HS_OFF: if (!w_hs_sync_q) begin
               r_ls_req <= 1'b1;
               r_state  <= LS_ON;
            end
            LS_ON: if (r_ls_enable) begin
               r_ls_sel <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= LS_RUN;
            end
            default: r_state <= LS_RUN;
         endcase
      end
   end

   assign clkout      = (w_hs_tap & r_hs_enable) | (lsclk_in & r_ls_enable);
   assign ls_selected = r_ls_sel;
   assign hs_selected = r_hs_sel;
   assign busy        = r_busy;
   assign div_active  = r_div_active;

endmodule

// File: tb/tb_clkswitch_seq.sv
// tb_clkswitch_seq: vector table, dwell/reset sequences and a randomised
// phase sweep for the clock switcher, with overlap and runt monitors.
module tb_clkswitch_seq;
   import clkswitch_pkg::*;

   localparam int DS      = 3;
   localparam int DS2     = 2;
   localparam int SW      = 2;
   localparam int PS      = 2;
   localparam int DW      = 4;
   localparam int DWW     = 3;
   localparam int LS_HALF = 80;

   logic          lsclk_in = 1'b0;
   logic          hsclk_in = 1'b0;
   logic          rst_b    = 1'b1;
   logic          hs_req   = 1'b0;
   logic [SW-1:0] div_sel  = '0;

   logic          clkout, ls_selected, hs_selected, busy;
   logic [SW-1:0] div_active;
   logic          clkout_2, ls_selected_2, hs_selected_2, busy_2;
   logic [SW-1:0] div_active_2;

   int  hs_half = 5;
   int  n_tests = 0;
   int  n_fail  = 0;
   int  n_overlap = 0;
   int  n_runt = 0;
   bit  rst_window = 1'b1;
   bit  edge_ok = 1'b0;
   real t_edge = 0.0, t_prev = 0.0, t_last = 0.0, t_hs_up = 0.0;

   initial forever #(LS_HALF) lsclk_in = ~lsclk_in;
   initial forever #(hs_half) hsclk_in = ~hsclk_in;

   clkswitch_seq #(
      .DIV_STAGES (DS), .SEL_W (SW), .PIPE_SZ (PS),
      .DWELL (DW), .DWELL_W (DWW)
   ) dut (
      .lsclk_in (lsclk_in), .rst_b (rst_b), .hsclk_in (hsclk_in),
      .hs_req (hs_req), .div_sel (div_sel), .clkout (clkout),
      .ls_selected (ls_selected), .hs_selected (hs_selected),
      .busy (busy), .div_active (div_active)
   );

   clkswitch_seq #(
      .DIV_STAGES (DS2), .SEL_W (SW), .PIPE_SZ (PS),
      .DWELL (DW), .DWELL_W (DWW)
   ) dut2 (
      .lsclk_in (lsclk_in), .rst_b (rst_b), .hsclk_in (hsclk_in),
      .hs_req (hs_req), .div_sel (div_sel), .clkout (clkout_2),
      .ls_selected (ls_selected_2), .hs_selected (hs_selected_2),
      .busy (busy_2), .div_active (div_active_2)
   );

   // Enables / selects must never be high together once things settle.
   always @(posedge dut.r_ls_enable or posedge dut.r_hs_enable or
            posedge dut2.r_ls_enable or posedge dut2.r_hs_enable or
            posedge ls_selected or posedge hs_selected) begin
      #1;
      if (dut.r_ls_enable && dut.r_hs_enable) n_overlap++;
      if (dut2.r_ls_enable && dut2.r_hs_enable) n_overlap++;
      if (ls_selected && hs_selected) n_overlap++;
   end

   always @(clkout) begin
      if (!rst_window && edge_ok && ($realtime - t_edge) < real'(hs_half))
         n_runt++;
      t_edge  = $realtime;
      edge_ok = !rst_window;
   end

   always @(posedge clkout) begin
      t_prev = t_last;
      t_last = $realtime;
   end

   always @(posedge hs_selected) t_hs_up = $realtime;

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_le(input string nm, input real act, input real lim);
      n_tests++;
      if (act > lim) begin
         n_fail++;
         $display("FAIL %s: got %0.1f, limit %0.1f", nm, act, lim);
      end
   endtask

   task automatic settle(input bit want_hs, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge lsclk_in);
         #1;
         if (hs_selected == want_hs && ls_selected == !want_hs && !busy &&
             hs_selected_2 == want_hs && ls_selected_2 == !want_hs && !busy_2) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic int clampm(input int sel, input int ds);
      return (sel > ds) ? ds : sel;
   endfunction

   typedef struct {
      bit req;
      int sel;
      bit exp_hs;
      int exp_div;
      int exp_div2;
   } vec_t;

   vec_t tbl[11];

   initial begin
      bit  ok;
      bit  prev_hs;
      int  n;
      int  sel;
      real t_req;
      longint exp_per;

      tbl[0]  = '{0, 0, 0, 0, 0};
      tbl[1]  = '{1, 2, 1, 2, 2};
      tbl[2]  = '{1, 0, 1, 2, 2};
      tbl[3]  = '{0, 0, 0, 2, 2};
      tbl[4]  = '{1, 0, 1, 0, 0};
      tbl[5]  = '{0, 3, 0, 0, 0};
      tbl[6]  = '{1, 3, 1, 3, 2};
      tbl[7]  = '{1, 1, 1, 3, 2};
      tbl[8]  = '{0, 1, 0, 3, 2};
      tbl[9]  = '{1, 1, 1, 1, 1};
      tbl[10] = '{0, 0, 0, 1, 1};

      #3 rst_b = 1'b0;
      #100;
      chk("rst_ls_sel", ls_selected, 1);
      chk("rst_hs_sel", hs_selected, 0);
      chk("rst_busy", busy, 0);
      chk("rst_div", div_active, 0);
      chk("rst_clkout", clkout, 1);
      #100 rst_b = 1'b1;
      @(negedge lsclk_in);
      rst_window = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(posedge lsclk_in); #1;
         chk("follow_hi", clkout, 1);
         @(negedge lsclk_in); #1;
         chk("follow_lo", clkout, 0);
      end
      chk("idle_ls_sel", ls_selected, 1);
      chk("idle_hs_sel", hs_selected, 0);
      chk("idle_busy", busy, 0);

      prev_hs = 1'b0;
      foreach (tbl[i]) begin
         div_sel = SW'(tbl[i].sel);
         hs_req  = tbl[i].req;
         t_req   = $realtime;
         repeat (8) @(posedge lsclk_in);
         settle(tbl[i].exp_hs, 60, ok);
         chk("vec_settle", ok, 1);
         if (tbl[i].exp_hs && !prev_hs && ok)
            chk_le("ls2hs_latency", t_hs_up - t_req,
                   real'((PS + 2) * ((2 * hs_half) << tbl[i].exp_div) +
                         (PS + 2) * 2 * LS_HALF));
         repeat (4) @(posedge lsclk_in);
         #1;
         chk("vec_hs_sel", hs_selected, tbl[i].exp_hs);
         chk("vec_ls_sel", ls_selected, !tbl[i].exp_hs);
         chk("vec_div", div_active, tbl[i].exp_div);
         chk("vec_div_clamp", div_active_2, tbl[i].exp_div2);
         exp_per = tbl[i].exp_hs ? longint'((2 * hs_half) << tbl[i].exp_div)
                                 : longint'(2 * LS_HALF);
         chk("vec_period", longint'(t_last - t_prev), exp_per);
         prev_hs = tbl[i].exp_hs;
      end

      div_sel = 2'd1;
      hs_req  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge lsclk_in); #1;
         if (hs_selected) begin
            ok = 1'b1;
            break;
         end
      end
      chk("dwell_reach_hs", ok, 1);
      @(posedge lsclk_in); #1;
      hs_req = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge lsclk_in); #1;
         n++;
         if (busy) break;
      end
      chk("dwell_cycles", n, DW);
      settle(1'b0, 60, ok);
      chk("dwell_back_ls", ok, 1);

      div_sel = 2'd3;
      hs_req  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         #1;
         if (dut.r_state == HS_ON) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach_hs_on", ok, 1);
      #2;
      rst_window = 1'b1;
      rst_b = 1'b0;
      #1;
      chk("mid_rst_state", dut.r_state == LS_RUN, 1);
      chk("mid_rst_ls_en", dut.r_ls_enable, 1);
      chk("mid_rst_hs_en", dut.r_hs_enable, 0);
      chk("mid_rst_ls_sel", ls_selected, 1);
      chk("mid_rst_hs_sel", hs_selected, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_div", div_active, 0);
      hs_req = 1'b0;
      #20 rst_b = 1'b1;
      @(negedge lsclk_in);
      @(negedge lsclk_in);
      rst_window = 1'b0;
      settle(1'b0, 10, ok);
      chk("post_rst_ls", ok, 1);

      for (int r = 0; r < 500; r++) begin
         hs_half = $urandom_range(3, 40);
         #($urandom_range(0, 400));
         sel = $urandom_range(0, 3);
         div_sel = SW'(sel);
         hs_req = 1'b1;
         settle(1'b1, 80, ok);
         chk("rnd_hs_div", ok ? longint'(div_active) : -1, clampm(sel, DS));
         chk("rnd_hs_div2", ok ? longint'(div_active_2) : -1, clampm(sel, DS2));
         #($urandom_range(0, 400));
         hs_req = 1'b0;
         settle(1'b0, 80, ok);
         chk("rnd_back_ls", ok, 1);
      end

      chk("enable_overlap", n_overlap, 0);
      chk("runt_pulses", n_runt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
